des_perm_pipe: RTL and testbench
================================

# des_perm_pipe

Parametrised, pipelined DES bit-permutation engine. Each 64-bit block is permuted by either the DES final permutation (FP) or its inverse, the initial permutation (IP), with an optional L/R half-swap before permuting. A selectable tag travels with each block. The engine sits between the round datapath and the stream interface, with valid/ready handshakes on both sides, a configurable register depth, a synchronous flush and a completed-block counter.

## Interface
- `PIPE_STAGES`, default 2: number of register stages. Legal range 1..4.
- `TAG_W`, default 4: width of the sideband tag carried alongside the data.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; drops all in-flight blocks.
- `in_valid`  in  1  input block is valid.
- `in_ready`  out  1  the engine accepts the input block this cycle.
- `in_data`  in  64  input block. Bit 63 is the MSB; bit indices are LSB-0.
- `in_mode`  in  1  0 = FP, 1 = IP.
- `in_swap`  in  1  1 = swap halves before permuting: `{in_data[31:0], in_data[63:32]}`.
- `in_tag`  in  TAG_W  tag delivered unchanged with the block.
- `out_valid`  out  1  output block is valid.
- `out_ready`  in  1  downstream accepts the output block.
- `out_data`  out  64  permuted block.
- `out_tag`  out  TAG_W  tag of the output block.
- `blk_cnt`  out  32  count of completed output handshakes.

## Operation
- Let x be the block after the optional swap.
- **FP definition.** For row j = 0..7 and column i = 0..7: `out[8j+i] = x[base(i) + 8*(i>>1) - j]`, where base(i) = 39 when i is even and 7 when i is odd.
  - Example: out[0]=x[39], out[1]=x[7], out[57]=x[0].
- **IP definition.** IP is the exact inverse of FP, so FP(IP(x)) = IP(FP(x)) = x for all x. If FP maps x[k] to out[m], then IP maps x[m] to out[k].
- The permutation and swap are combinational in front of stage 1. Stages 2..PIPE_STAGES are pure registers.
- **Stage contents.** Each stage holds valid, data[63:0] and tag.
- **Stage advance.** Stage s advances when `ready_s = !v[s] | ready_{s+1}`; the last stage uses `out_ready` as its downstream ready. `in_ready = ready_1 & !flush`.
- **Outputs.** `out_valid`, `out_data` and `out_tag` come straight from the last stage's registers (registered outputs).
- **Handshake rules.**
  - A transfer occurs when valid & ready are both high at a clock edge.
  - While `out_valid=1` and `out_ready=0`, `out_data` and `out_tag` must hold stable.
  - Upstream may not retract `in_valid` before a transfer; the engine does not rely on this.
- **Flush.**
  - On a cycle with `flush=1`, all stage valids clear at the next edge.
  - `in_ready=0` during that cycle, so no input is captured.
  - Data registers are not cleared.
  - `blk_cnt` is unaffected, except that an output handshake occurring in the same cycle still counts.
- **blk_cnt.**
  - Increments by 1 on each output transfer.
  - Wraps from 0xFFFF_FFFF to 0.
  - Cleared only by `rst`.
- **Reset (asynchronous, immediate).**
  - All stage valids, data and tags go to 0.
  - `out_valid=0`, `out_data=0`, `out_tag=0`, `blk_cnt=0`.
  - `in_ready` reads 1 once `rst` is deasserted, with `flush` low.
  - Reset mid-stream discards all in-flight blocks, with no partial output.

## Timing
- **Latency.** A block accepted at edge N appears with `out_valid=1` after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles from presentation to availability with no stalls. With `PIPE_STAGES=1`, output is valid the cycle after acceptance.
- **Throughput.** One block per cycle while `out_ready=1`.
- **Ready path.** `in_ready` depends combinationally on `out_ready` through the ready chain. There is no skid buffer.
- **Full pipeline.** All stages valid and `out_ready=0` gives `in_ready=0`. When `out_ready` rises, all stages shift and `in_ready=1` in the same cycle.
- **Bubbles.** An invalid stage always accepts, so bubbles collapse under backpressure.
- **Mode changes.** `in_mode` and `in_swap` are sampled per block at acceptance and may change every cycle.

## Test plan
- **Single-bit vectors.** Use FP, no swap, PIPE_STAGES=2, `out_ready=1`.
  - in=64'h0000_0000_0000_0001 → out=64'h0200_0000_0000_0000, 2 cycles later.
  - in=64'h0000_0080_0000_0000 (bit 39) → out=64'h1.
- **IP round-trip.** IP of 64'h0200_0000_0000_0000 → 64'h1. Then 1000 random blocks through IP, re-injected with FP, each equal to its original; tags preserved in order.
- **Swap.** FP with in_swap=1 on 64'h0000_0001_0000_0000 → 64'h0200_0000_0000_0000, matching the first vector.
- **Backpressure.**
  - Stream 8 blocks with `out_ready` toggling randomly.
  - No loss or duplication; `out_data` stable while stalled.
  - `in_ready=0` only when all PIPE_STAGES are full and `out_ready=0`.
  - `blk_cnt=8` at the end.
- **Flush and reset.**
  - Fill the pipeline and assert `flush` for one cycle: `out_valid=0` on the next cycle, `in_ready=0` during the flush cycle, `blk_cnt` unchanged.
  - Assert `rst` mid-stream: all outputs 0 immediately, with no output afterwards until a new input arrives.
- **Depth sweep and wrap.**
  - Repeat the latency check for PIPE_STAGES=1..4: measured latency must equal PIPE_STAGES.
  - Force `blk_cnt` to 0xFFFF_FFFF; one more transfer must give 0.

Source files
------------

// File: rtl/des_perm_pipe.sv
// Pipelined DES bit-permutation engine: optional L/R half-swap, then FP or IP,
// followed by PIPE_STAGES valid/ready register stages and a completed-block counter.
module des_perm_pipe #(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_mode,
  input  logic             in_swap,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      blk_cnt
);

  localparam int unsigned S = PIPE_STAGES;

  logic [63:0]                 w_x;
  logic [63:0]                 w_fp;
  logic [63:0]                 w_ip;
  logic [63:0]                 w_perm;
  logic [S:0]                  w_rdy;
  logic                        w_out_fire;

  logic [S-1:0]                r_vld;
  logic [S-1:0][63:0]          r_data;
  logic [S-1:0][TAG_W-1:0]     r_tag;
  logic [31:0]                 r_blk_cnt;

  assign w_x = in_swap ? {in_data[31:0], in_data[63:32]} : in_data;

  // FP wiring: out[8j+i] = x[base(i) + 8*(i>>1) - j]; IP is the same wiring reversed.
  for (genvar j = 0; j < 8; j++) begin : g_row
    for (genvar i = 0; i < 8; i++) begin : g_col
      localparam int Src = (((i % 2) == 0) ? 39 : 7) + 8 * (i / 2) - j;
      assign w_fp[8*j+i] = w_x[Src];
      assign w_ip[Src]   = w_x[8*j+i];
    end
  end

  assign w_perm = in_mode ? w_ip : w_fp;

  // Ready chain from the output back to stage 1; an empty stage always accepts.
  always_comb begin
    w_rdy    = '0;
    w_rdy[S] = out_ready;
    for (int s = int'(S) - 1; s >= 0; s--) begin
      w_rdy[s] = ~r_vld[s] | w_rdy[s+1];
    end
  end

  assign in_ready   = w_rdy[0] & ~flush;
  assign w_out_fire = r_vld[S-1] & out_ready;

  // Stage registers: stage 1 captures the permuted input, later stages shift.
  // Data/tag only load with a valid block so a stalled output stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_data <= '0;
      r_tag  <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_perm;
          r_tag[0]  <= in_tag;
        end
      end
      for (int s = 1; s < int'(S); s++) begin
        if (w_rdy[s]) begin
          r_vld[s] <= r_vld[s-1];
          if (r_vld[s-1]) begin
            r_data[s] <= r_data[s-1];
            r_tag[s]  <= r_tag[s-1];
          end
        end
      end
    end
  end

  // Completed-output counter; wraps naturally, only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_cnt <= '0;
    end else if (w_out_fire) begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign out_valid = r_vld[S-1];
  assign out_data  = r_data[S-1];
  assign out_tag   = r_tag[S-1];
  assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: vectors, IP/FP round trip, backpressure,
// flush, reset, depth sweep (1..4) and counter wrap.
module tb_des_perm_pipe;

  localparam int unsigned TW  = 4;
  localparam int unsigned NRT = 1000;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_mode, in_swap, out_ready;
  logic [63:0]   in_data;
  logic [TW-1:0] in_tag;

  logic          in_ready_v  [4];
  logic          out_valid_v [4];
  logic [63:0]   out_data_v  [4];
  logic [TW-1:0] out_tag_v   [4];
  logic [31:0]   blk_cnt_v   [4];

  int total = 0;
  int bad   = 0;

  logic [TW+63:0] exp_q[$];
  logic [63:0]    cap_q[$];
  logic [63:0]    orig [NRT];
  logic [63:0]    ipo  [NRT];
  bit             stalled;
  logic [63:0]    stall_data;
  logic [TW-1:0]  stall_tag;

  always #5 clk = ~clk;

  // Index 1 (PIPE_STAGES=2) is the main DUT; the others only serve the depth sweep.
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    des_perm_pipe #(.PIPE_STAGES(g + 1), .TAG_W(TW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_swap   (in_swap),
      .in_tag    (in_tag),
      .out_valid (out_valid_v[g]),
      .out_ready ((g == 1) ? out_ready : 1'b1),
      .out_data  (out_data_v[g]),
      .out_tag   (out_tag_v[g]),
      .blk_cnt   (blk_cnt_v[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        y[8*j+i] = x[(((i % 2) == 0) ? 39 : 7) + 8 * (i / 2) - j];
    return y;
  endfunction

  // IP derived from FP by probing with unit vectors: FP sends bit k to the set bit of f.
  function automatic logic [63:0] ref_ip(input logic [63:0] x);
    logic [63:0] y;
    logic [63:0] f;
    y = '0;
    for (int k = 0; k < 64; k++) begin
      f    = ref_fp(64'd1 << k);
      y[k] = |(x & f);
    end
    return y;
  endfunction

  function automatic logic [63:0] ref_perm(input logic [63:0] d, input bit mode, input bit swap);
    logic [63:0] xs;
    xs = swap ? {d[31:0], d[63:32]} : d;
    return mode ? ref_ip(xs) : ref_fp(xs);
  endfunction

  // One cycle on the main DUT; entered just after a negedge with inputs driven.
  task automatic tick(input logic [63:0] exp_data, output bit acc);
    logic [TW+63:0] e;
    #1;
    chk("in_ready_model", 64'(in_ready_v[1]),
        64'(!(exp_q.size() == 2 && !out_ready) && !flush));
    if (stalled) begin
      chk("stall_valid", 64'(out_valid_v[1]), 64'd1);
      chk("stall_data", out_data_v[1], stall_data);
      chk("stall_tag", 64'(out_tag_v[1]), 64'(stall_tag));
    end
    acc = in_valid && in_ready_v[1];
    if (out_valid_v[1] && exp_q.size() == 0) begin
      chk("spurious_valid", 64'(out_valid_v[1]), 64'd0);
    end else if (out_valid_v[1] && out_ready) begin
      e = exp_q.pop_front();
      chk("stream_data", out_data_v[1], e[63:0]);
      chk("stream_tag", 64'(out_tag_v[1]), 64'(e[TW+63:64]));
      cap_q.push_back(out_data_v[1]);
    end
    stalled    = out_valid_v[1] && !out_ready;
    stall_data = out_data_v[1];
    stall_tag  = out_tag_v[1];
    if (acc) exp_q.push_back({in_tag, exp_data});
    @(negedge clk);
  endtask

  // Streams n blocks; from_ipo re-injects captured IP outputs expecting the originals.
  task automatic stream(input int n, input bit mode, input bit from_ipo, input bit rnd);
    int          idx;
    int          cyc;
    bit          acc;
    logic [63:0] d;
    logic [63:0] ed;
    idx     = 0;
    cyc     = 0;
    stalled = 0;
    cap_q.delete();
    while ((idx < n || exp_q.size() != 0) && cyc < n * 4 + 40) begin
      d        = from_ipo ? ipo[(idx < n) ? idx : 0] : orig[(idx < n) ? idx : 0];
      in_valid = (idx < n);
      in_data  = d;
      in_mode  = rnd ? ((idx % 4) >= 2) : mode;
      in_swap  = rnd ? ((idx % 2) == 1) : 1'b0;
      in_tag   = TW'(idx);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      ed = from_ipo ? orig[(idx < n) ? idx : 0] : ref_perm(d, in_mode, in_swap);
      tick(ed, acc);
      if (acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("stream_accepted", 64'(idx), 64'(n));
  endtask

  // Single block at full throughput; must appear after exactly two edges.
  task automatic single(input string name, input logic [63:0] d, input bit mode, input bit swap,
                        input logic [TW-1:0] tag, input logic [63:0] exp);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = mode;
    in_swap  = swap;
    in_tag   = tag;
    #1 chk({name, "_in_ready"}, 64'(in_ready_v[1]), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({name, "_early"}, 64'(out_valid_v[1]), 64'd0);
    @(negedge clk);
    #1;
    chk({name, "_valid"}, 64'(out_valid_v[1]), 64'd1);
    chk({name, "_data"}, out_data_v[1], exp);
    chk({name, "_tag"}, 64'(out_tag_v[1]), 64'(tag));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat [4];
    logic [31:0] cnt0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_swap   = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    stalled   = 0;
    for (int k = 0; k < int'(NRT); k++) orig[k] = {$urandom, $urandom};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid_v[1]), 64'd0);
    chk("rst_out_data", out_data_v[1], 64'd0);
    chk("rst_out_tag", 64'(out_tag_v[1]), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt_v[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready_v[1]), 64'd1);
    @(negedge clk);

    single("fp_bit0", 64'h0000_0000_0000_0001, 1'b0, 1'b0, 4'h5, 64'h0200_0000_0000_0000);
    single("fp_bit39", 64'h0000_0080_0000_0000, 1'b0, 1'b0, 4'hA, 64'h0000_0000_0000_0001);
    single("fp_swap", 64'h0000_0001_0000_0000, 1'b0, 1'b1, 4'h3, 64'h0200_0000_0000_0000);
    single("ip_bit57", 64'h0200_0000_0000_0000, 1'b1, 1'b0, 4'hF, 64'h0000_0000_0000_0001);
    #1 chk("cnt_after_vectors", 64'(blk_cnt_v[1]), 64'd4);
    @(negedge clk);

    // IP round trip: 1000 blocks through IP, then back through FP.
    stream(NRT, 1'b1, 1'b0, 1'b0);
    chk("ip_capture_count", 64'(cap_q.size()), 64'(NRT));
    for (int k = 0; k < int'(NRT); k++) ipo[k] = (k < cap_q.size()) ? cap_q[k] : 64'd0;
    stream(NRT, 1'b0, 1'b1, 1'b0);
    #1 chk("cnt_after_roundtrip", 64'(blk_cnt_v[1]), 64'd2004);
    @(negedge clk);

    // Reset mid-stream.
    in_valid = 1'b1;
    in_data  = orig[0];
    in_tag   = 4'h1;
    @(negedge clk);
    in_data  = orig[1];
    in_tag   = 4'h2;
    @(negedge clk);
    #1 chk("midrst_pre_valid", 64'(out_valid_v[1]), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid_v[1]), 64'd0);
    chk("midrst_out_data", out_data_v[1], 64'd0);
    chk("midrst_out_tag", 64'(out_tag_v[1]), 64'd0);
    chk("midrst_blk_cnt", 64'(blk_cnt_v[1]), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    stalled  = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("midrst_no_output", 64'(out_valid_v[1]), 64'd0);
      @(negedge clk);
    end

    // Backpressure: 8 blocks, random out_ready, mixed modes and swaps.
    stream(8, 1'b0, 1'b0, 1'b1);
    #1 chk("bp_blk_cnt", 64'(blk_cnt_v[1]), 64'd8);
    @(negedge clk);

    // Flush with a full pipeline.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_swap   = 1'b0;
    in_data   = orig[5];
    in_tag    = 4'h6;
    @(negedge clk);
    in_data = orig[6];
    in_tag  = 4'h7;
    @(negedge clk);
    #1;
    chk("full_in_ready", 64'(in_ready_v[1]), 64'd0);
    chk("full_out_valid", 64'(out_valid_v[1]), 64'd1);
    chk("full_out_data", out_data_v[1], ref_fp(orig[5]));
    out_ready = 1'b1;
    #1 chk("full_release_in_ready", 64'(in_ready_v[1]), 64'd1);
    out_ready = 1'b0;
    in_data   = orig[7];
    flush     = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready_v[1]), 64'd0);
    cnt0 = blk_cnt_v[1];
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid_v[1]), 64'd0);
    chk("flush_blk_cnt", 64'(blk_cnt_v[1]), 64'(cnt0));
    chk("flush_in_ready_after", 64'(in_ready_v[1]), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("flush_stays_empty", 64'(out_valid_v[1]), 64'd0);
    @(negedge clk);

    // Depth sweep: edges from acceptance to out_valid must equal PIPE_STAGES.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) lat[g] = 0;
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_0001;
    in_mode  = 1'b0;
    in_tag   = 4'h9;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) in_valid = 1'b0;
      for (int g = 0; g < 4; g++) if (out_valid_v[g] && lat[g] == 0) lat[g] = k;
    end
    for (int g = 0; g < 4; g++) chk($sformatf("latency_depth%0d", g + 1), 64'(lat[g]), 64'(g + 1));
    @(negedge clk);

    // Counter wrap.
    force gen_dut[1].u_dut.r_blk_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release gen_dut[1].u_dut.r_blk_cnt;
    @(negedge clk);
    single("wrap_blk", 64'h0000_0080_0000_0000, 1'b0, 1'b0, 4'h2, 64'h0000_0000_0000_0001);
    #1 chk("wrap_blk_cnt", 64'(blk_cnt_v[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
